// File: rtl/dpram_fifo_ctrl_if.sv
// rtl/dpram_fifo_ctrl_if.sv - push/pop stream and dpram port bundle for dpram_fifo_ctrl
interface dpram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH+1:0] level;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Environment side: stream producer/consumer plus the RAM read data.
  modport master (
    output flush, wr_valid, wr_data, rd_ready, ram_dout,
    input  wr_ready, rd_valid, rd_data, level,
    input  ram_waddr, ram_we, ram_din, ram_raddr, ram_re
  );

  // Controller side.
  modport slave (
    input  flush, wr_valid, wr_data, rd_ready, ram_dout,
    output wr_ready, rd_valid, rd_data, level,
    output ram_waddr, ram_we, ram_din, ram_raddr, ram_re
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - RAM-backed stream FIFO controller with 2-entry prefetch buffer
module dpram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  dpram_fifo_ctrl_if.slave   bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int LW = ADDR_WIDTH + 2;

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         ram_cnt;
  logic                  inflight;
  logic [1:0]            buf_cnt;
  logic [1:0]            cnt_after;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  push;
  logic                  pop;
  logic                  fetch;

  // Handshakes, fetch decision and RAM port drive. ram_cnt never exceeds
  // DEPTH, so its top bit alone marks the RAM as full.
  always_comb begin
    ram_cnt   = wptr - rptr;
    push      = bus.wr_valid & ~ram_cnt[ADDR_WIDTH] & ~bus.flush & ~rst;
    pop       = (buf_cnt != 2'd0) & bus.rd_ready;
    cnt_after = buf_cnt - {1'b0, pop};
    // inflight + buf_cnt never exceeds 2, so occ fits in two bits.
    occ       = {1'b0, inflight} + cnt_after;
    fetch     = ~bus.flush & (ram_cnt != '0) & (occ < 2'd2);

    bus.wr_ready  = ~ram_cnt[ADDR_WIDTH];
    bus.rd_valid  = (buf_cnt != 2'd0);
    bus.rd_data   = (buf_cnt != 2'd0) ? buf0 : '0;
    bus.level     = LW'(ram_cnt) + LW'(inflight) + LW'(buf_cnt);
    bus.ram_we    = push;
    bus.ram_waddr = wptr[ADDR_WIDTH-1:0];
    bus.ram_din   = bus.wr_data;
    bus.ram_re    = fetch;
    bus.ram_raddr = rptr[ADDR_WIDTH-1:0];
  end

  // Pointers and the read-in-flight flag; flush drops any pending read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
    end else if (bus.flush) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + PW'(1);
      if (fetch) rptr <= rptr + PW'(1);
      inflight <= fetch;
    end
  end

  // Prefetch buffer: pop shifts the skid slot forward, then returning RAM
  // data lands in the first slot left free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0    <= '0;
      buf1    <= '0;
      buf_cnt <= 2'd0;
    end else if (bus.flush) begin
      buf_cnt <= 2'd0;
    end else begin
      if (pop && buf_cnt == 2'd2) buf0 <= buf1;
      if (inflight) begin
        if (cnt_after == 2'd0) buf0 <= bus.ram_dout;
        else                   buf1 <= bus.ram_dout;
      end
      buf_cnt <= cnt_after + {1'b0, inflight};
    end
  end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - scoreboard bench for dpram_fifo_ctrl with behavioural dpram
module tb_dpram_fifo_ctrl;
  localparam int AW = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // dpram_sclk model: registered read, dout 0 unless re was high last cycle
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_din;
    bus.ram_dout <= bus.ram_re ? mem[bus.ram_raddr] : '0;
  end

  int total = 0;
  int bad = 0;
  logic [DW-1:0] q[$];
  int  pop_cnt = 0;
  bit  gap_chk = 0;
  bit  seen_first = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    bus.flush    = fl;
    #1;
  endtask

  task automatic monitor();
    logic [DW-1:0] exp;
    check("level", 64'(bus.level), 64'(q.size()));
    if (!bus.rd_valid) check("rd_data_idle", 64'(bus.rd_data), 64'(0));
    if (bus.ram_we && bus.ram_re)
      check("addr_collision", 64'(bus.ram_waddr != bus.ram_raddr), 64'(1));
    if (gap_chk && seen_first && q.size() > 0)
      check("no_gap", 64'(bus.rd_valid), 64'(1));
    if (bus.flush) begin
      q.delete();
    end else begin
      if (bus.rd_valid && bus.rd_ready) begin
        if (q.size() == 0) begin
          check("pop_on_empty", 64'(q.size()), 64'(1));
        end else begin
          exp = q.pop_front();
          check("rd_data", 64'(bus.rd_data), 64'(exp));
          pop_cnt++;
          seen_first = 1;
        end
      end
      if (bus.wr_valid && bus.wr_ready) q.push_back(bus.wr_data);
    end
  endtask

  task automatic tick();
    monitor();
    @(negedge clk);
  endtask

  task automatic run_basic(input string p);
    drive(1'b1, 32'hA5, 1'b0, 1'b0);
    check({p, "_c0_we"}, 64'(bus.ram_we), 64'(1));
    check({p, "_c0_waddr"}, 64'(bus.ram_waddr), 64'(0));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check({p, "_c1_re"}, 64'(bus.ram_re), 64'(1));
    check({p, "_c1_raddr"}, 64'(bus.ram_raddr), 64'(0));
    check({p, "_c1_rd_valid"}, 64'(bus.rd_valid), 64'(0));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check({p, "_c2_rd_valid"}, 64'(bus.rd_valid), 64'(0));
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    check({p, "_c3_rd_valid"}, 64'(bus.rd_valid), 64'(1));
    check({p, "_c3_rd_data"}, 64'(bus.rd_data), 64'(32'hA5));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check({p, "_c4_empty"}, 64'(bus.rd_valid), 64'(0));
    tick();
  endtask

  initial begin
    int acc;
    int start_pops;
    bit got;

    // Reset state
    drive(1'b0, '0, 1'b0, 1'b0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    check("rst_rd_data", 64'(bus.rd_data), 64'(0));
    check("rst_level", 64'(bus.level), 64'(0));
    check("rst_ram_we", 64'(bus.ram_we), 64'(0));
    check("rst_ram_re", 64'(bus.ram_re), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_wr_ready", 64'(bus.wr_ready), 64'(1));

    // Single word latency
    run_basic("t1");

    // Fill with consumer stalled: 4 in RAM + 2 in buffer
    acc = 0;
    for (int i = 0; i < 20 && acc < 6; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
      if (bus.wr_ready) acc++;
      tick();
    end
    check("t2_accepted", 64'(acc), 64'(6));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300, 1'b0, 1'b0);
      check("t2_full_wr_ready", 64'(bus.wr_ready), 64'(0));
      check("t2_full_level", 64'(bus.level), 64'(6));
      tick();
    end
    // Flush a full FIFO with both buffer slots occupied
    drive(1'b1, 32'h301, 1'b1, 1'b1);
    check("t2_flush_we", 64'(bus.ram_we), 64'(0));
    check("t2_flush_re", 64'(bus.ram_re), 64'(0));
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t2_after_flush_valid", 64'(bus.rd_valid), 64'(0));
    check("t2_after_flush_level", 64'(bus.level), 64'(0));
    tick();

    // Continuous stream 0..99
    gap_chk = 1;
    seen_first = 0;
    start_pops = pop_cnt;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      check("t3_wr_ready", 64'(bus.wr_ready), 64'(1));
      tick();
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    gap_chk = 0;
    check("t3_pop_count", 64'(pop_cnt - start_pops), 64'(100));

    // Flush with a read in flight and a word buffered
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    check("t5_flush_re", 64'(bus.ram_re), 64'(0));
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      check("t5_valid_after_flush", 64'(bus.rd_valid), 64'(0));
      check("t5_level_after_flush", 64'(bus.level), 64'(0));
      tick();
    end
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    tick();
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (bus.rd_valid) begin
        check("t5_next_word", 64'(bus.rd_data), 64'(32'h11));
        got = 1;
      end
      tick();
    end
    check("t5_word_seen", 64'(got), 64'(1));

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
      tick();
    end
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    check("t4_drained", 64'(q.size()), 64'(0));

    // Asynchronous reset mid-burst
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h500 + 32'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 32'h5FF, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rd_valid", 64'(bus.rd_valid), 64'(0));
    check("t6_rd_data", 64'(bus.rd_data), 64'(0));
    check("t6_level", 64'(bus.level), 64'(0));
    check("t6_ram_we", 64'(bus.ram_we), 64'(0));
    check("t6_ram_re", 64'(bus.ram_re), 64'(0));
    q.delete();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_wr_ready", 64'(bus.wr_ready), 64'(1));
    run_basic("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
